// File: rtl/fattree_addr_codec_pkg.sv
// Shared fat-tree sizing helpers: log2 and the widths derived from arity K and level count L.
// Used by the address codec and by other fat-tree blocks that carry digit-coded endpoint addresses.
package fattree_addr_codec_pkg;

  // clog2-style, except that log2(x<=1) = 1, so a field is never zero bits wide
  function automatic int log2(input int x);
    int r;
    if (x <= 1) return 1;
    r = 0;
    while ((1 << r) < x) r++;
    return r;
  endfunction

  function automatic int calc_ne(input int k, input int l);
    int p;
    p = 1;
    for (int i = 0; i < l; i++) p = p * k;
    return p;
  endfunction

  function automatic int calc_kw(input int k);
    return log2(k);
  endfunction

  function automatic int calc_eaw(input int k, input int l);
    return l * log2(k);
  endfunction

  function automatic int calc_new(input int k, input int l);
    return log2(calc_ne(k, l));
  endfunction

  function automatic bit is_pow2(input int x);
    return (x > 0) && ((x & (x - 1)) == 0);
  endfunction

endpackage

// File: rtl/fattree_addr_encoder.sv
// Combinational flat-ID to base-K digit-code converter; digit 0 (leaf) sits in the LSB field.
module fattree_addr_encoder
  import fattree_addr_codec_pkg::*;
#(
  parameter int K = 2,
  parameter int L = 2,
  localparam int NE  = calc_ne(K, L),
  localparam int Kw  = calc_kw(K),
  localparam int EAw = calc_eaw(K, L),
  localparam int NEw = log2(NE)
) (
  input  logic [NEw-1:0] id,
  output logic [EAw-1:0] code
);

  generate
    if (is_pow2(K)) begin : g_pow2
      // with K = 2**Kw every digit is simply the next Kw-bit slice of the ID
      assign code = id;
    end else begin : g_arith
      localparam int WW = NEw + Kw;
      localparam logic [WW-1:0] K_W = WW'(K);
      logic [WW-1:0] rem;

      always_comb begin
        code = '0;
        rem  = WW'(id);
        for (int i = 0; i < L; i++) begin
          code[i*Kw +: Kw] = Kw'(rem % K_W);
          rem = rem / K_W;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/fattree_addr_codec.sv
// Registered endpoint-address codec (flat ID <-> per-level base-K digits), one cycle each way.
// Range-error flags are built only when FATTREE_ADDR_CODEC_RANGE_CHECK_EN is defined.
module fattree_addr_codec
  import fattree_addr_codec_pkg::*;
#(
  parameter int K = 2,
  parameter int L = 2,
  localparam int NE  = calc_ne(K, L),
  localparam int Kw  = calc_kw(K),
  localparam int EAw = calc_eaw(K, L),
  localparam int NEw = log2(NE)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           enc_valid_in,
  input  logic [NEw-1:0] enc_id_in,
  output logic           enc_valid_out,
  output logic [EAw-1:0] enc_code_out,
  output logic           enc_err,
  input  logic           dec_valid_in,
  input  logic [EAw-1:0] dec_code_in,
  output logic           dec_valid_out,
  output logic [NEw-1:0] dec_id_out,
  output logic           dec_err
);

  logic [EAw-1:0] enc_code_next;
  logic [NEw-1:0] dec_id_next;

  fattree_addr_encoder #(
    .K(K),
    .L(L)
  ) u_encoder (
    .id  (enc_id_in),
    .code(enc_code_next)
  );

  generate
    if (is_pow2(K)) begin : g_dec_pow2
      assign dec_id_next = dec_code_in;
    end else begin : g_dec_arith
      // Horner accumulation; wrap-around above NEw bits matches the final truncation
      localparam int DW = NEw + Kw;
      localparam logic [DW-1:0] K_D = DW'(K);
      logic [DW-1:0] acc;

      always_comb begin
        acc = '0;
        for (int i = L - 1; i >= 0; i--) begin
          acc = acc * K_D + DW'(dec_code_in[i*Kw +: Kw]);
        end
      end

      assign dec_id_next = NEw'(acc);
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enc_valid_out <= 1'b0;
      enc_code_out  <= '0;
      dec_valid_out <= 1'b0;
      dec_id_out    <= '0;
    end else begin
      enc_valid_out <= enc_valid_in;
      dec_valid_out <= dec_valid_in;
      if (enc_valid_in) enc_code_out <= enc_code_next;
      if (dec_valid_in) dec_id_out <= dec_id_next;
    end
  end

`ifdef FATTREE_ADDR_CODEC_RANGE_CHECK_EN
  logic dec_digit_bad;

  always_comb begin
    dec_digit_bad = 1'b0;
    for (int i = 0; i < L; i++) begin
      if (32'(dec_code_in[i*Kw +: Kw]) >= K) dec_digit_bad = 1'b1;
    end
  end

  // error flags travel with their data and share its load enable
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enc_err <= 1'b0;
      dec_err <= 1'b0;
    end else begin
      if (enc_valid_in) enc_err <= (32'(enc_id_in) >= NE);
      if (dec_valid_in) dec_err <= dec_digit_bad;
    end
  end
`else
  assign enc_err = 1'b0;
  assign dec_err = 1'b0;
`endif

endmodule

// File: tb/tb_fattree_addr_codec.sv
// Directed bench for fattree_addr_codec: K=3,L=2 arithmetic path and K=4,L=3 identity path.
module tb_fattree_addr_codec;

`ifdef FATTREE_ADDR_CODEC_RANGE_CHECK_EN
  localparam logic RC = 1'b1;
`else
  localparam logic RC = 1'b0;
`endif

  logic clk;
  logic reset;

  logic       e3_vi, e3_vo, e3_err, d3_vi, d3_vo, d3_err;
  logic [3:0] e3_id, e3_code, d3_code, d3_id;

  logic       e4_vi, e4_vo, e4_err, d4_vi, d4_vo, d4_err;
  logic [5:0] e4_id, e4_code, d4_code, d4_id;

  int n_checks = 0;
  int n_fail   = 0;

  fattree_addr_codec #(.K(3), .L(2)) u3 (
    .clk          (clk),
    .reset        (reset),
    .enc_valid_in (e3_vi),
    .enc_id_in    (e3_id),
    .enc_valid_out(e3_vo),
    .enc_code_out (e3_code),
    .enc_err      (e3_err),
    .dec_valid_in (d3_vi),
    .dec_code_in  (d3_code),
    .dec_valid_out(d3_vo),
    .dec_id_out   (d3_id),
    .dec_err      (d3_err)
  );

  fattree_addr_codec #(.K(4), .L(3)) u4 (
    .clk          (clk),
    .reset        (reset),
    .enc_valid_in (e4_vi),
    .enc_id_in    (e4_id),
    .enc_valid_out(e4_vo),
    .enc_code_out (e4_code),
    .enc_err      (e4_err),
    .dec_valid_in (d4_vi),
    .dec_code_in  (d4_code),
    .dec_valid_out(d4_vo),
    .dec_id_out   (d4_id),
    .dec_err      (d4_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0;
    e3_vi = 0; e3_id = '0; d3_vi = 0; d3_code = '0;
    e4_vi = 0; e4_id = '0; d4_vi = 0; d4_code = '0;
    #1 reset = 1'b1;
    #1;
    checkOutput("rst_e3_vo", e3_vo, 0);
    checkOutput("rst_e3_code", e3_code, 0);
    checkOutput("rst_e3_err", e3_err, 0);
    checkOutput("rst_d3_vo", d3_vo, 0);
    checkOutput("rst_d3_id", d3_id, 0);
    checkOutput("rst_d3_err", d3_err, 0);
    checkOutput("rst_e4_vo", e4_vo, 0);
    checkOutput("rst_d4_id", d4_id, 0);
    #6 reset = 1'b0;

    $display("[TB] K=3 L=2 directed vectors");
    e3_vi = 1; e3_id = 4'd7; d3_vi = 1; d3_code = 4'b1010;
    applyStimulus();
    checkOutput("enc7_vo", e3_vo, 1);
    checkOutput("enc7_code", e3_code, 4'b1001);
    checkOutput("enc7_err", e3_err, 0);
    checkOutput("dec1010_vo", d3_vo, 1);
    checkOutput("dec1010_id", d3_id, 8);
    checkOutput("dec1010_err", d3_err, 0);

    e3_id = 4'd9; d3_code = 4'b0000;
    applyStimulus();
    checkOutput("enc9_code", e3_code, 4'b0000);
    checkOutput("enc9_err", e3_err, RC);
    checkOutput("dec0000_id", d3_id, 0);
    checkOutput("dec0000_err", d3_err, 0);

    e3_id = 4'd8; d3_code = 4'b0011;
    applyStimulus();
    checkOutput("enc8_code", e3_code, 4'b1010);
    checkOutput("enc8_err", e3_err, 0);
    checkOutput("dec0011_id", d3_id, 3);
    checkOutput("dec0011_err", d3_err, RC);

    e3_id = 4'd15; d3_code = 4'b1111;
    applyStimulus();
    checkOutput("enc15_code", e3_code, 4'b1000);
    checkOutput("enc15_err", e3_err, RC);
    checkOutput("dec1111_id", d3_id, 12);
    checkOutput("dec1111_err", d3_err, RC);

    e3_id = 4'd5; d3_code = 4'b0101;
    applyStimulus();
    checkOutput("enc5_code", e3_code, 4'b0110);
    checkOutput("enc5_err", e3_err, 0);
    checkOutput("dec0101_id", d3_id, 4);
    checkOutput("dec0101_err", d3_err, 0);

    $display("[TB] valid gap, data must hold");
    e3_vi = 0; d3_vi = 0; e3_id = 4'd1; d3_code = 4'b0001;
    for (int g = 0; g < 3; g++) begin
      applyStimulus();
      checkOutput("gap_e3_vo", e3_vo, 0);
      checkOutput("gap_e3_code", e3_code, 4'b0110);
      checkOutput("gap_d3_vo", d3_vo, 0);
      checkOutput("gap_d3_id", d3_id, 4);
    end

    e3_vi = 1; e3_id = 4'd4; d3_vi = 1; d3_code = 4'b1001;
    applyStimulus();
    checkOutput("post_gap_e3_vo", e3_vo, 1);
    checkOutput("enc4_code", e3_code, 4'b0101);
    checkOutput("post_gap_d3_vo", d3_vo, 1);
    checkOutput("dec1001_id", d3_id, 7);
    e3_vi = 0; d3_vi = 0;

    $display("[TB] K=4 L=3 encode->decode sweep");
    for (int i = 0; i <= 64; i++) begin
      if (i < 64) begin
        e4_vi = 1; e4_id = 6'(i);
      end else begin
        e4_vi = 0;
      end
      d4_vi   = (i > 0);
      d4_code = e4_code;
      applyStimulus();
      if (i < 64) begin
        checkOutput("sweep_e4_vo", e4_vo, 1);
        checkOutput("sweep_e4_code", e4_code, i);
      end else begin
        checkOutput("sweep_end_e4_vo", e4_vo, 0);
      end
      if (i > 0) begin
        checkOutput("sweep_d4_vo", d4_vo, 1);
        checkOutput("sweep_d4_id", d4_id, i - 1);
      end
    end
    checkOutput("sweep_e4_err", e4_err, 0);
    checkOutput("sweep_d4_err", d4_err, 0);
    d4_vi = 0;

    $display("[TB] asynchronous reset mid-stream");
    e3_vi = 1; e3_id = 4'd7; d3_vi = 1; d3_code = 4'b1010;
    e4_vi = 1; e4_id = 6'd63; d4_vi = 1; d4_code = 6'h2A;
    applyStimulus();
    checkOutput("pre_rst_e3_code", e3_code, 4'b1001);
    checkOutput("pre_rst_d3_id", d3_id, 8);
    checkOutput("pre_rst_e4_code", e4_code, 63);
    checkOutput("pre_rst_d4_id", d4_id, 42);
    #2 reset = 1'b1;
    #1;
    checkOutput("arst_e3_vo", e3_vo, 0);
    checkOutput("arst_e3_code", e3_code, 0);
    checkOutput("arst_d3_vo", d3_vo, 0);
    checkOutput("arst_d3_id", d3_id, 0);
    checkOutput("arst_e4_vo", e4_vo, 0);
    checkOutput("arst_e4_code", e4_code, 0);
    checkOutput("arst_d4_vo", d4_vo, 0);
    checkOutput("arst_d4_id", d4_id, 0);
    e3_vi = 0; d3_vi = 0; e4_vi = 0; d4_vi = 0;
    #1 reset = 1'b0;
    for (int c = 0; c < 2; c++) begin
      applyStimulus();
      checkOutput("idle_e3_vo", e3_vo, 0);
      checkOutput("idle_e3_code", e3_code, 0);
      checkOutput("idle_d3_vo", d3_vo, 0);
      checkOutput("idle_d4_id", d4_id, 0);
    end
    e3_vi = 1; e3_id = 4'd7;
    applyStimulus();
    checkOutput("first_e3_vo", e3_vo, 1);
    checkOutput("first_e3_code", e3_code, 4'b1001);
    checkOutput("first_d3_vo", d3_vo, 0);
    e3_vi = 0;
    applyStimulus();
    checkOutput("after_e3_vo", e3_vo, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
